seq_datapath: RTL and testbench

Parametrised single-bus datapath with a built-in micro-step sequencer. It executes one register-to-register ALU operation, or one iterative unsigned multiply, per start handshake. Operands move over one internal bus: register file → Y → ALU → Z → register file or HI/LO. It replaces hand-driven per-cycle enable/bus-select control for the next-generation CPU core, and exposes a debug read port for the bench.

---
 rtl/seq_datapath_pkg.sv | 54 +++++
 rtl/seq_datapath_alu.sv | 45 ++++
 rtl/seq_datapath.sv | 254 +++++++++++++++++++++++++
 tb/tb_seq_datapath.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_datapath_pkg
// Description : Shared types and constants for the single-bus sequenced
//               datapath: opcode and sequencer state encodings, last legal
//               opcode and the shift-amount width helper.
//               Optional feature macro: SEQ_DATAPATH_MUL_EN (iterative MUL).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_datapath_pkg;

    // ALU / sequencer opcodes; values 10..15 are illegal
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_SHRA = 4'd6,
        OP_NOT  = 4'd7,
        OP_NEG  = 4'd8,
        OP_MUL  = 4'd9
    } op_e;

    // Micro-step sequencer states; the multiply states exist only when the
    // multiplier is built
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_Y   = 3'd1,
        S_EXEC     = 3'd2,
        S_WB_LO    = 3'd3,
        S_DONE     = 3'd4
`ifdef SEQ_DATAPATH_MUL_EN
        ,
        S_MUL_ITER = 3'd5,
        S_WB_HI    = 3'd6
`endif
    } state_e;

    // Highest opcode the sequencer accepts without flagging an error
`ifdef SEQ_DATAPATH_MUL_EN
    localparam logic [3:0] OP_LAST_LEGAL = 4'd9;
`else
    localparam logic [3:0] OP_LAST_LEGAL = 4'd8;
`endif

    // Number of low operand bits used as a shift amount for a given width
    function automatic int shamtWidth(input int dataW);
        return $clog2(dataW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_datapath_alu
// Description : Combinational ALU of the sequenced datapath. Computes
//               f(A, B) for every non-multiply opcode; shifts use the low
//               shamtWidth(DATA_W) bits of B. Multiply and illegal opcodes
//               return zero (the multiply is iterated in the top level).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_datapath_alu
    import seq_datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_e               i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);

    localparam int SHAMT_W = shamtWidth(DATA_W);

    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt = i_b[SHAMT_W-1:0];

    // Opcode-selected result; everything wraps modulo 2^DATA_W
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_SHL:  o_result = i_a << w_shamt;
            OP_SHR:  o_result = i_a >> w_shamt;
            OP_SHRA: o_result = $signed(i_a) >>> w_shamt;
            OP_NOT:  o_result = ~i_a;
            OP_NEG:  o_result = '0 - i_a;
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_datapath.sv
`default_nettype none
// ============================================================================
// Module      : seq_datapath
// Description : Single-bus datapath with built-in micro-step sequencer.
//               One register-to-register ALU op (or one iterative unsigned
//               multiply) per start handshake. Transfers follow
//               register file -> Y -> ALU -> Z -> register file or HI/LO.
//               R0 reads as zero and ignores writes. Debug read port exposes
//               the register file combinationally.
//               Optional feature macro: SEQ_DATAPATH_MUL_EN enables opcode 9
//               (shift-add multiply into HI/LO); without it opcode 9 errors.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 16,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic              ready,
    input  logic [3:0]        op,
    input  logic [RW-1:0]     ra,
    input  logic [RW-1:0]     rb,
    input  logic [RW-1:0]     rc,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [DATA_W-1:0] bus_out,
    input  logic [RW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e              r_state;
    logic [3:0]          r_op;
    logic [RW-1:0]       r_ra;
    logic [RW-1:0]       r_rb;
    logic [RW-1:0]       r_rc;
    logic                r_immSel;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_regs [NREGS];
    logic [DATA_W-1:0]   r_y;
    logic [DATA_W-1:0]   r_zLo;
    logic                r_ready;
    logic                r_done;
    logic                r_err;

    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_rbData;
    logic [DATA_W-1:0]   w_rcData;
    logic [DATA_W-1:0]   w_aluResult;
    logic                w_opLegal;

`ifdef SEQ_DATAPATH_MUL_EN
    localparam int SHAMT_W = shamtWidth(DATA_W);
    localparam logic [SHAMT_W-1:0] c_cntLast = SHAMT_W'(DATA_W - 1);

    logic [DATA_W-1:0]   r_zHi;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_m;
    logic [SHAMT_W-1:0]  r_cnt;

    logic                w_isMul;
    logic [DATA_W-1:0]   w_addend;
    logic [DATA_W:0]     w_mulSum;
`endif

    // ------------------------------------------------------------------
    // Register file read ports; R0 is hardwired to zero
    // ------------------------------------------------------------------
    assign w_rbData = (r_rb == '0)    ? '0 : r_regs[r_rb];
    assign w_rcData = (r_rc == '0)    ? '0 : r_regs[r_rc];
    assign dbg_data = (dbg_sel == '0) ? '0 : r_regs[dbg_sel];

    assign w_opLegal = (op <= OP_LAST_LEGAL);

    // Single internal bus: each state drives exactly one source, else zero
    always_comb begin
        w_bus = '0;
        case (r_state)
            S_LOAD_Y: w_bus = w_rbData;
            S_EXEC:   w_bus = r_immSel ? r_imm : w_rcData;
`ifdef SEQ_DATAPATH_MUL_EN
            S_WB_HI:  w_bus = r_zHi;
`endif
            S_WB_LO:  w_bus = r_zLo;
            default:  w_bus = '0;
        endcase
    end

    seq_datapath_alu #(
        .DATA_W   (DATA_W)
    ) u_alu (
        .i_op     (op_e'(r_op)),
        .i_a      (r_y),
        .i_b      (w_bus),
        .o_result (w_aluResult)
    );

`ifdef SEQ_DATAPATH_MUL_EN
    // One shift-add step: add Y into the upper half when the current
    // multiplier bit is set, keeping the carry for the right shift
    assign w_isMul  = (r_op == OP_MUL);
    assign w_addend = r_m[r_cnt] ? r_y : '0;
    assign w_mulSum = {1'b0, r_zHi} + {1'b0, w_addend};
`endif

    // Sequencer: state, operand latches, Y/Z, register file and HI/LO
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rc     <= '0;
            r_immSel <= 1'b0;
            r_imm    <= '0;
            r_y      <= '0;
            r_zLo    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
`ifdef SEQ_DATAPATH_MUL_EN
            r_zHi    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_ra     <= ra;
                        r_rb     <= rb;
                        r_rc     <= rc;
                        r_immSel <= imm_sel;
                        r_imm    <= imm;
                        r_ready  <= 1'b0;
                        if (w_opLegal) begin
                            r_state <= S_LOAD_Y;
                        end else begin
                            // Illegal opcode skips straight to completion
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end

                S_LOAD_Y: begin
                    r_y     <= w_bus;
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    r_zLo <= w_aluResult;
`ifdef SEQ_DATAPATH_MUL_EN
                    r_zHi <= '0;
                    if (w_isMul) begin
                        r_zLo   <= '0;
                        r_m     <= w_bus;
                        r_cnt   <= '0;
                        r_state <= S_MUL_ITER;
                    end else begin
                        r_state <= S_WB_LO;
                    end
`else
                    r_state <= S_WB_LO;
`endif
                end

`ifdef SEQ_DATAPATH_MUL_EN
                S_MUL_ITER: begin
                    r_zHi <= w_mulSum[DATA_W:1];
                    r_zLo <= {w_mulSum[0], r_zLo[DATA_W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cntLast) begin
                        r_state <= S_WB_HI;
                    end
                end

                S_WB_HI: begin
                    r_hi    <= w_bus;
                    r_state <= S_WB_LO;
                end
`endif

                S_WB_LO: begin
`ifdef SEQ_DATAPATH_MUL_EN
                    if (w_isMul) begin
                        r_lo <= w_bus;
                    end else if (r_ra != '0) begin
                        r_regs[r_ra] <= w_bus;
                    end
`else
                    if (r_ra != '0) begin
                        r_regs[r_ra] <= w_bus;
                    end
`endif
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_err   <= 1'b0;
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready   = r_ready;
    assign done    = r_done;
    assign err     = r_err;
    assign bus_out = w_bus;

`ifdef SEQ_DATAPATH_MUL_EN
    assign hi_out = r_hi;
    assign lo_out = r_lo;
`else
    assign hi_out = '0;
    assign lo_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_datapath
// Description : Self-checking bench for seq_datapath (DATA_W=32, NREGS=16).
//               Directed steps followed by random operations, checked
//               against an arithmetic reference model of the register file
//               and HI/LO. Honours SEQ_DATAPATH_MUL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_datapath;

    localparam int DW = 32;
    localparam int NR = 16;

`ifdef SEQ_DATAPATH_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic          ready;
    logic [3:0]    op;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [3:0]    rc;
    logic          imm_sel;
    logic [DW-1:0] imm;
    logic          done;
    logic          err;
    logic [DW-1:0] hi_out;
    logic [DW-1:0] lo_out;
    logic [DW-1:0] bus_out;
    logic [3:0]    dbg_sel;
    logic [DW-1:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] mR [NR];
    logic [DW-1:0] mHi;
    logic [DW-1:0] mLo;
    logic [DW-1:0] busLog [$];

    always #20 clk = ~clk;

    seq_datapath #(
        .DATA_W (DW),
        .NREGS  (NR)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .ready    (ready),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .imm_sel  (imm_sel),
        .imm      (imm),
        .done     (done),
        .err      (err),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .bus_out  (bus_out),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int i);
        return (i == 0) ? '0 : mR[i];
    endfunction

    // Operation semantics from first principles
    function automatic logic [DW-1:0] refAlu(input int o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh;
        sh = int'(b % 32);
        case (o)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a << sh;
            5: return a >> sh;
            6: return a[DW-1] ? ~((~a) >> sh) : (a >> sh);
            7: return ~a;
            8: return 32'd0 - a;
            default: return '0;
        endcase
    endfunction

    task automatic readReg(input int i, output logic [DW-1:0] v);
        dbg_sel = 4'(i);
        #1;
        v = dbg_data;
    endtask

    task automatic checkState();
        logic [DW-1:0] v;
        for (int i = 0; i < NR; i++) begin
            readReg(i, v);
            check($sformatf("R%0d", i), 64'(v), 64'(rd(i)));
        end
        check("hi_out", 64'(hi_out), 64'(mHi));
        check("lo_out", 64'(lo_out), 64'(mLo));
    endtask

    task automatic modelClear();
        for (int i = 0; i < NR; i++) mR[i] = '0;
        mHi = '0;
        mLo = '0;
    endtask

    // Apply reset for one edge, check the reset outputs, then release
    task automatic doReset();
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        modelClear();
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_bus", 64'(bus_out), 64'd0);
        checkState();
        clr = 1'b1;
    endtask

    // Run one operation end to end; poke pulses start during LOAD_Y and DONE
    task automatic runOp(input int o, input int raI, input int rbI, input int rcI,
                         input bit immSelI, input logic [DW-1:0] immI, input bit poke);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [63:0]   p;
        bit            legal;
        bit            isMul;
        int            expLat;
        int            lat;

        a      = rd(rbI);
        b      = immSelI ? immI : rd(rcI);
        isMul  = MUL_EN && (o == 9);
        legal  = (o <= 8) || isMul;
        expLat = !legal ? 0 : (isMul ? DW + 4 : 3);
        busLog.delete();

        @(negedge clk);
        op      = 4'(o);
        ra      = 4'(raI);
        rb      = 4'(rbI);
        rc      = 4'(rcI);
        imm_sel = immSelI;
        imm     = immI;
        start   = 1'b1;
        check("ready_idle", 64'(ready), 64'd1);
        @(posedge clk);
        for (lat = 0; lat < 200; lat++) begin
            @(negedge clk);
            busLog.push_back(bus_out);
            start = poke && (lat == 0 || done);
            check("ready_busy", 64'(ready), 64'd0);
            if (done) break;
        end
        check($sformatf("latency_op%0d", o), 64'(lat), 64'(expLat));
        check($sformatf("err_op%0d", o), 64'(err), 64'(!legal));
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'(done), 64'd0);
        check("ready_back", 64'(ready), 64'd1);
        if (poke) begin
            @(negedge clk);
            check("start_ignored", 64'(ready), 64'd1);
        end

        if (legal) begin
            if (isMul) begin
                p   = {32'd0, a} * {32'd0, b};
                mHi = p[63:32];
                mLo = p[31:0];
            end else if (raI != 0) begin
                mR[raI] = refAlu(o, a, b);
            end
        end
        checkState();
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        int            o;

        clr     = 1'b0;
        start   = 1'b0;
        op      = '0;
        ra      = '0;
        rb      = '0;
        rc      = '0;
        imm_sel = 1'b0;
        imm     = '0;
        dbg_sel = '0;
        modelClear();

        repeat (2) @(posedge clk);
        doReset();

        // Preset R2=7, R3=5 through R0 + immediate
        runOp(0, 2, 0, 0, 1'b1, 32'd7, 1'b0);
        runOp(0, 3, 0, 0, 1'b1, 32'd5, 1'b0);

        // ADD R1 = R2 + R3 with bus trace
        runOp(0, 1, 2, 3, 1'b0, 32'd0, 1'b0);
        readReg(1, v);
        check("add_r1", 64'(v), 64'd12);
        check("bus_len", 64'(busLog.size()), 64'd4);
        if (busLog.size() == 4) begin
            check("bus_loady", 64'(busLog[0]), 64'd7);
            check("bus_exec", 64'(busLog[1]), 64'd5);
            check("bus_wblo", 64'(busLog[2]), 64'd12);
            check("bus_done", 64'(busLog[3]), 64'd0);
        end

        // SUB R4 = R3 - R2
        runOp(1, 4, 3, 2, 1'b0, 32'd0, 1'b0);
        readReg(4, v);
        check("sub_r4", 64'(v), 64'hFFFF_FFFE);

        // SHRA of 0x8000_0000 by immediate 4
        runOp(0, 5, 0, 0, 1'b1, 32'h8000_0000, 1'b0);
        runOp(6, 6, 5, 0, 1'b1, 32'd4, 1'b0);
        readReg(6, v);
        check("shra_r6", 64'(v), 64'hF800_0000);

        // Illegal opcode: immediate done+err, nothing changes
        runOp(12, 7, 2, 3, 1'b0, 32'd0, 1'b0);

        // Opcode 9: full multiply, or illegal when the multiplier is absent
        runOp(0, 2, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        runOp(0, 3, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        runOp(9, 1, 2, 3, 1'b0, 32'd0, 1'b0);
        if (MUL_EN) begin
            check("mul_hi", 64'(hi_out), 64'hFFFF_FFFE);
            check("mul_lo", 64'(lo_out), 64'h0000_0001);
        end else begin
            check("nomul_hi", 64'(hi_out), 64'd0);
            check("nomul_lo", 64'(lo_out), 64'd0);
        end

        // Write to R0 discarded
        runOp(0, 0, 2, 3, 1'b0, 32'd0, 1'b0);
        readReg(0, v);
        check("r0_zero", 64'(v), 64'd0);

        // start pulsed during LOAD_Y and DONE is ignored
        runOp(0, 8, 4, 6, 1'b0, 32'd0, 1'b1);

        // Reset mid-operation (inside MUL_ITER when the multiplier exists)
        @(negedge clk);
        op      = MUL_EN ? 4'd9 : 4'd0;
        ra      = 4'd1;
        rb      = 4'd2;
        rc      = 4'd3;
        imm_sel = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (MUL_EN ? 8 : 1) @(negedge clk);
        doReset();

        // Normal operation after reset
        runOp(0, 2, 0, 0, 1'b1, 32'd3, 1'b0);
        runOp(0, 1, 2, 0, 1'b1, 32'd4, 1'b0);
        readReg(1, v);
        check("post_rst_add", 64'(v), 64'd7);

        // Random fill, then random operations
        for (int i = 1; i < NR; i++) begin
            runOp(0, i, 0, 0, 1'b1, 32'($urandom), 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) o = $urandom_range(10, 15);
            else                           o = $urandom_range(0, 9);
            runOp(o, $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                  $urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
                  32'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
